lmsm_expander: RTL
==================

Name: lmsm_expander

Overview:
- Sits between instruction fetch and the control decoder. It performs the opposite job to decoding: it encodes micro-op instruction words.
- LM (opcode 1100) and SM (opcode 1101) are expanded into a sequence of single LW (0100) and SW (0101) instruction words. The existing decoder then handles these without modification.
- All other instructions pass through unchanged with one registered stage.
- Valid/ready handshake on both sides, so expansion stalls fetch.

Parameters:
- IW, 16, instruction width (fixed ISA width; no other value is supported)
- NREG, 8, register count / LM-SM list width

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- in_instr  input  16  fetched instruction word
- in_valid  input  1  in_instr valid
- in_ready  output  1  expander accepts in_instr this cycle (combinational)
- flush  input  1  synchronous kill (taken branch/jump), discards held and pending work
- out_instr  output  16  instruction word to decoder (registered)
- out_valid  output  1  out_instr valid (registered)
- out_ready  input  1  decoder/pipeline accepts out_instr
- out_last  output  1  out_instr is the final micro-op of an LM/SM, or a pass-through instruction
- busy  output  1  state==EXPAND

Behaviour:
- Field definitions for LM/SM:
  - opcode = in_instr[15:12]
  - base = in_instr[11:9]
  - list = in_instr[7:0]
  - in_instr[8] is ignored
  - list bit i selects register Ri
- Micro-op encoding, with k = 3-bit transfer counter (0..7) zero-extended to 6 bits:
  - LW = {4'b0100, Ri, base, k}
  - SW = {4'b0101, Ri, base, k}
- Registers are emitted in ascending index order, lowest set bit first.
- Handshakes:
  - Input transfer = in_valid && in_ready.
  - Output transfer = out_valid && out_ready.
  - in_ready = !rst && !flush && state==IDLE && (!out_valid || out_ready).
- States:
  - IDLE: pass-through or start of expansion.
  - EXPAND: out register holds a micro-op; remaining list is non-empty or the last micro-op is unaccepted.
- IDLE, on input transfer:
  - Non-LM/SM: next cycle out_instr=in_instr, out_valid=1, out_last=1.
  - LM/SM with list!=0:
    - Latch the type, base and list.
    - Next cycle: out_instr = micro-op for the lowest set bit with k=0, out_valid=1.
    - Clear that bit from the remaining list; k<=1.
    - out_last=1 if no bits remain.
    - state<=EXPAND.
  - LM/SM with list==0: instruction consumed, nothing emitted, out_valid<=0, stay IDLE.
  - No input transfer and out_ready: out_valid<=0.
- EXPAND, on output transfer:
  - Remaining list non-empty: load the next micro-op with the current k, clear its bit, k<=k+1, out_last=(remaining==0 after clear).
  - Remaining list empty: out_valid<=0, out_last<=0, state<=IDLE.
  - This costs one bubble cycle before the next input is accepted.
- EXPAND without output transfer: hold all outputs and state; out_instr stays stable while out_valid && !out_ready.
- flush (priority over everything except rst):
  - Next cycle: out_valid=0, out_last=0, state=IDLE, remaining list=0, k=0.
  - Input is not accepted in the flush cycle.
- Reset: out_instr=16'h0000, out_valid=0, out_last=0, busy=0, state=IDLE, list=0, k=0. Reset mid-expansion abandons the sequence.
- Counter k never exceeds 7 (at most 8 transfers); no wrap is required.

Test Plan:
- Reset, then in=0x1234 valid, out_ready=1 -> next cycle out_instr=0x1234, out_valid=1, out_last=1, busy=0.
- LM 0xC6A5 (base R3, list 10100101), out_ready=1 -> outputs on consecutive cycles:
  - 0x40C0
  - 0x44C1
  - 0x4AC2
  - 0x4EC3, with out_last only on this word
  - then one bubble; in_ready=0 throughout EXPAND.
- SM 0xD203, with out_ready held low 3 cycles on the first word -> 0x5040 held stable for those cycles, then 0x5241 with out_last=1.
- LM 0xC700 (empty list) -> consumed in one cycle, no out_valid, next instruction accepted the following cycle.
- LM with list 0xFF, flush asserted after the 3rd micro-op -> out_valid=0 next cycle, busy=0, and the next accepted instruction passes through correctly.
- rst asserted mid-expansion of LM 0xC6FF -> next cycle all outputs at their reset values; a subsequent SM 0xD281 produces 0x5040 then 0x5E41 (R0, R7).

Source files
------------

// File: rtl/lmsm_expander.sv
// lmsm_expander: turns LM/SM (load/store multiple) instruction words into a
// sequence of single LW/SW words so the downstream decoder never sees LM/SM.
// All other instructions pass through one registered stage unchanged.
// Valid/ready on both sides; while an expansion is running, fetch is stalled.

module lmsm_expander #(
    parameter int IW   = 16,   // instruction width, fixed by the ISA
    parameter int NREG = 8     // register count == LM/SM list width
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [IW-1:0]   in_instr,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            flush,
    output logic [IW-1:0]   out_instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_last,
    output logic            busy
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_EXPAND = 1'b1
    } state_t;

    localparam logic [3:0] OP_LM = 4'b1100;
    localparam logic [3:0] OP_SM = 4'b1101;
    localparam logic [3:0] OP_LW = 4'b0100;
    localparam logic [3:0] OP_SW = 4'b0101;

    // Index of the lowest set bit; the list is walked in ascending order.
    function automatic logic [2:0] lsb_index(input logic [NREG-1:0] list);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (list[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

    // Remove the lowest set bit (classic x & (x-1)).
    function automatic logic [NREG-1:0] clear_lsb(input logic [NREG-1:0] list);
        return list & (list - {{(NREG-1){1'b0}}, 1'b1});
    endfunction

    // Build one LW/SW micro-op: {opcode, Ri, base, zero-extended k}.
    function automatic logic [IW-1:0] encode_uop(input logic       is_sm,
                                                 input logic [2:0] reg_idx,
                                                 input logic [2:0] base,
                                                 input logic [2:0] k);
        return {(is_sm ? OP_SW : OP_LW), reg_idx, base, 3'b000, k};
    endfunction

    // State and datapath registers
    state_t             r_state;
    logic [IW-1:0]      r_out_instr;
    logic               r_out_valid;
    logic               r_out_last;
    logic [NREG-1:0]    r_list;      // registers still to be emitted
    logic [2:0]         r_base;
    logic               r_is_sm;
    logic [2:0]         r_k;         // index of the next micro-op in the sequence

    // Next-state values
    state_t             w_state_n;
    logic [IW-1:0]      w_out_instr_n;
    logic               w_out_valid_n;
    logic               w_out_last_n;
    logic [NREG-1:0]    w_list_n;
    logic [2:0]         w_base_n;
    logic               w_is_sm_n;
    logic [2:0]         w_k_n;

    // Decode helpers
    logic               w_in_xfer;
    logic               w_out_xfer;
    logic               w_is_lmsm;
    logic               w_in_is_sm;
    logic [NREG-1:0]    w_in_list;
    logic [2:0]         w_in_base;
    logic [2:0]         w_in_lsb;
    logic [NREG-1:0]    w_in_rem;
    logic [2:0]         w_r_lsb;
    logic [NREG-1:0]    w_r_rem;

    assign w_in_list  = in_instr[NREG-1:0];
    assign w_in_base  = in_instr[11:9];
    assign w_in_is_sm = (in_instr[15:12] == OP_SM);
    assign w_is_lmsm  = (in_instr[15:12] == OP_LM) || (in_instr[15:12] == OP_SM);
    assign w_in_lsb   = lsb_index(w_in_list);
    assign w_in_rem   = clear_lsb(w_in_list);
    assign w_r_lsb    = lsb_index(r_list);
    assign w_r_rem    = clear_lsb(r_list);

    // Fetch is accepted only when idle and the output slot is free or draining.
    assign in_ready   = !rst && !flush && (r_state == ST_IDLE) &&
                        (!r_out_valid || out_ready);
    assign w_in_xfer  = in_valid && in_ready;
    assign w_out_xfer = r_out_valid && out_ready;

    assign out_instr  = r_out_instr;
    assign out_valid  = r_out_valid;
    assign out_last   = r_out_last;
    assign busy       = (r_state == ST_EXPAND);

    // Next-state and next-output logic; everything holds unless changed below.
    always_comb begin
        w_state_n     = r_state;
        w_out_instr_n = r_out_instr;
        w_out_valid_n = r_out_valid;
        w_out_last_n  = r_out_last;
        w_list_n      = r_list;
        w_base_n      = r_base;
        w_is_sm_n     = r_is_sm;
        w_k_n         = r_k;

        if (flush) begin
            w_out_valid_n = 1'b0;
            w_out_last_n  = 1'b0;
            w_state_n     = ST_IDLE;
            w_list_n      = {NREG{1'b0}};
            w_k_n         = 3'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_in_xfer) begin
                        if (w_is_lmsm) begin
                            if (w_in_list != {NREG{1'b0}}) begin
                                w_is_sm_n     = w_in_is_sm;
                                w_base_n      = w_in_base;
                                w_out_instr_n = encode_uop(w_in_is_sm, w_in_lsb,
                                                           w_in_base, 3'd0);
                                w_out_valid_n = 1'b1;
                                w_out_last_n  = (w_in_rem == {NREG{1'b0}});
                                w_list_n      = w_in_rem;
                                w_k_n         = 3'd1;
                                w_state_n     = ST_EXPAND;
                            end else begin
                                // Empty list: swallow the word, emit nothing.
                                w_out_valid_n = 1'b0;
                            end
                        end else begin
                            w_out_instr_n = in_instr;
                            w_out_valid_n = 1'b1;
                            w_out_last_n  = 1'b1;
                        end
                    end else if (out_ready) begin
                        w_out_valid_n = 1'b0;
                    end else begin
                        w_out_valid_n = r_out_valid;
                    end
                end
                ST_EXPAND: begin
                    if (w_out_xfer) begin
                        if (r_list != {NREG{1'b0}}) begin
                            w_out_instr_n = encode_uop(r_is_sm, w_r_lsb, r_base, r_k);
                            w_out_last_n  = (w_r_rem == {NREG{1'b0}});
                            w_list_n      = w_r_rem;
                            w_k_n         = r_k + 3'd1;
                        end else begin
                            // Final micro-op taken: one bubble before next fetch.
                            w_out_valid_n = 1'b0;
                            w_out_last_n  = 1'b0;
                            w_state_n     = ST_IDLE;
                        end
                    end else begin
                        w_state_n = ST_EXPAND;
                    end
                end
                default: begin
                    w_state_n     = ST_IDLE;
                    w_out_valid_n = 1'b0;
                    w_out_last_n  = 1'b0;
                    w_list_n      = {NREG{1'b0}};
                    w_k_n         = 3'd0;
                end
            endcase
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_out_instr <= {IW{1'b0}};
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_list      <= {NREG{1'b0}};
            r_base      <= 3'd0;
            r_is_sm     <= 1'b0;
            r_k         <= 3'd0;
        end else begin
            r_state     <= w_state_n;
            r_out_instr <= w_out_instr_n;
            r_out_valid <= w_out_valid_n;
            r_out_last  <= w_out_last_n;
            r_list      <= w_list_n;
            r_base      <= w_base_n;
            r_is_sm     <= w_is_sm_n;
            r_k         <= w_k_n;
        end
    end

endmodule
